uart_word_loader: RTL and testbench

Boot-loader stage directly downstream of the UART receiver, in the same clock domain.
- Consumes the receiver's toggle-style byte strobe and byte value.
- Parses a 2-byte little-endian word-count header, then packs the payload bytes four at a time, little-endian, into 32-bit words.
- Writes each word to instruction memory through a valid/ready port at incrementing word addresses, then holds `done` so the CPU can leave reset.

---
 rtl/uart_word_loader.sv | 126 ++++++++++++
 tb/tb_uart_word_loader.sv | 135 +++++++++++++
 2 files changed

// File: rtl/uart_word_loader.sv
// uart_word_loader: parses a length header from UART bytes and writes packed LE words to memory
module uart_word_loader #(
  parameter int ADDR_WIDTH     = 16,
  parameter int BASE_ADDR      = 0,
  parameter int TIMEOUT_CYCLES = 262143
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_update,
  input  logic [7:0]            rx_byte,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output logic                  timeout
);
  typedef enum logic [2:0] {HDR0, HDR1, DATA, DRAIN, FIN} state_t;
  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d, word_cnt_q, word_cnt_d;
  logic [23:0]           asm_q, asm_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [19:0]           idle_q, idle_d;
  logic                  armed_q, armed_d, upd_prev_q, upd_prev_d;
  logic                  mem_valid_q, mem_valid_d, done_q, done_d;
  logic                  overrun_q, overrun_d, timeout_q, timeout_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  byte_evt, idle_run, idle_hit;
  assign byte_evt  = armed_q & (rx_update ^ upd_prev_q);
  assign idle_run  = (state_q == HDR1) || (state_q == DATA);
  assign idle_hit  = idle_run && !byte_evt && (idle_q + 20'd1 == 20'(TIMEOUT_CYCLES));
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q == HDR1) || (state_q == DATA) || (state_q == DRAIN);
  assign done      = done_q;
  assign overrun   = overrun_q;
  assign timeout   = timeout_q;
  // Next-state: header parse, word packing, write handshake and idle timeout
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    asm_d       = asm_q;
    byte_idx_d  = byte_idx_q;
    word_cnt_d  = word_cnt_q;
    armed_d     = 1'b1;
    upd_prev_d  = rx_update;
    mem_valid_d = mem_valid_q & ~mem_ready;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q | (state_q == FIN);
    overrun_d   = overrun_q;
    timeout_d   = timeout_q | idle_hit;
    idle_d      = (byte_evt || !idle_run || idle_hit) ? 20'd0 : idle_q + 20'd1;
    case (state_q)
      HDR0: if (byte_evt) begin
        len_d[7:0] = rx_byte;
        state_d    = HDR1;
      end
      HDR1: if (byte_evt) begin
        len_d[15:8] = rx_byte;
        state_d     = ({rx_byte, len_q[7:0]} == 16'd0) ? FIN : DATA;
        byte_idx_d  = 2'd0;
        word_cnt_d  = 16'd0;
      end
      DATA: if (byte_evt) begin
        asm_d      = {rx_byte, asm_q[23:8]};
        byte_idx_d = byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3) begin
          if (!mem_valid_q || mem_ready) begin
            mem_valid_d = 1'b1;
            mem_wdata_d = {rx_byte, asm_q};
            mem_addr_d  = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'({word_cnt_q, 2'b00});
          end else begin
            overrun_d = 1'b1;
          end
          word_cnt_d = word_cnt_q + 16'd1;
          state_d    = (word_cnt_q + 16'd1 == len_q) ? DRAIN : DATA;
        end
      end
      DRAIN: state_d = mem_valid_q ? DRAIN : FIN;
      default: ;
    endcase
    if (idle_hit) begin
      state_d    = HDR0;
      byte_idx_d = 2'd0;
    end
  end
  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HDR0;
      len_q       <= '0;
      asm_q       <= '0;
      byte_idx_q  <= '0;
      word_cnt_q  <= '0;
      idle_q      <= '0;
      armed_q     <= 1'b0;
      upd_prev_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= ADDR_WIDTH'(BASE_ADDR);
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      asm_q       <= asm_d;
      byte_idx_q  <= byte_idx_d;
      word_cnt_q  <= word_cnt_d;
      idle_q      <= idle_d;
      armed_q     <= armed_d;
      upd_prev_q  <= upd_prev_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end
endmodule

// File: tb/tb_uart_word_loader.sv
// tb_uart_word_loader: directed checks of header parsing, packing, overrun, timeout and wrap
module tb_uart_word_loader;
  logic        clk = 1'b0;
  logic        rst_n [2];
  logic        upd   [2];
  logic        ready [2];
  logic [7:0]  rxb   [2];
  logic        valid [2];
  logic        busy  [2];
  logic        done  [2];
  logic        ovr   [2];
  logic        tmo   [2];
  logic [15:0] addr  [2];
  logic [31:0] wdata [2];
  logic [47:0] wq0 [$];
  logic [47:0] wq1 [$];
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  uart_word_loader u_a (
    .clk(clk), .rst_n(rst_n[0]), .rx_update(upd[0]), .rx_byte(rxb[0]),
    .mem_valid(valid[0]), .mem_ready(ready[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]),
    .busy(busy[0]), .done(done[0]), .overrun(ovr[0]), .timeout(tmo[0])
  );
  uart_word_loader #(.ADDR_WIDTH(16), .BASE_ADDR(16'hFFFC), .TIMEOUT_CYCLES(50)) u_b (
    .clk(clk), .rst_n(rst_n[1]), .rx_update(upd[1]), .rx_byte(rxb[1]),
    .mem_valid(valid[1]), .mem_ready(ready[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]),
    .busy(busy[1]), .done(done[1]), .overrun(ovr[1]), .timeout(tmo[1])
  );
  // Record every completed handshake as {addr, data}
  always @(posedge clk) begin
    if (valid[0] && ready[0]) wq0.push_back({addr[0], wdata[0]});
    if (valid[1] && ready[1]) wq1.push_back({addr[1], wdata[1]});
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input int d, input logic [7:0] b);
    rxb[d] = b;
    upd[d] = ~upd[d];
    @(negedge clk);
  endtask
  task automatic do_reset(input int d);
    rst_n[d] = 1'b0;
    @(negedge clk);
    rst_n[d] = 1'b1;
    if (d == 0) wq0.delete(); else wq1.delete();
    @(negedge clk);
  endtask
  task automatic wait_done(input int d);
    for (int i = 0; i < 100 && !done[d]; i++) @(negedge clk);
  endtask
  task automatic send_seq(input int d, input logic [7:0] b [$]);
    foreach (b[i]) send(d, b[i]);
  endtask
  initial begin
    logic [7:0] p8 [$];
    p8 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    rst_n = '{1'b0, 1'b0};
    upd   = '{1'b1, 1'b0};
    ready = '{1'b1, 1'b1};
    rxb   = '{8'h00, 8'h00};
    repeat (2) @(negedge clk);
    rst_n = '{1'b1, 1'b1};
    repeat (100) @(negedge clk);
    chk("rst_valid", valid[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_addr", addr[0], 16'h0000);
    chk("rst_wdata", wdata[0], 0);
    chk("rst_flags", {ovr[0], tmo[0]}, 0);
    chk("rst_nowrite", wq0.size(), 0);
    chk("rst_addr_b", addr[1], 16'hFFFC);
    send(0, 8'h02);
    chk("hdr1_busy", busy[0], 1);
    send(0, 8'h00);
    send_seq(0, p8);
    wait_done(0);
    chk("w2_count", wq0.size(), 2);
    chk("w2_first", wq0.size() > 0 ? wq0[0] : 48'h0, {16'h0000, 32'h44332211});
    chk("w2_second", wq0.size() > 1 ? wq0[1] : 48'h0, {16'h0004, 32'h88776655});
    chk("w2_done", done[0], 1);
    chk("w2_busy", busy[0], 0);
    do_reset(0);
    chk("reset_clears_done", done[0], 0);
    send(0, 8'h00);
    send(0, 8'h00);
    @(negedge clk);
    chk("len0_done", done[0], 1);
    chk("len0_busy", busy[0], 0);
    send_seq(0, '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
    repeat (3) @(negedge clk);
    chk("len0_ignored", {wq0.size(), valid[0]}, 0);
    do_reset(0);
    ready[0] = 1'b0;
    send(0, 8'h02);
    send(0, 8'h00);
    send_seq(0, p8);
    chk("ovr_flag", ovr[0], 1);
    chk("ovr_hold", {valid[0], addr[0], wdata[0]}, {1'b1, 16'h0000, 32'h44332211});
    repeat (5) @(negedge clk);
    chk("ovr_stable", {valid[0], addr[0], wdata[0]}, {1'b1, 16'h0000, 32'h44332211});
    chk("ovr_not_done", {done[0], busy[0]}, 2'b01);
    ready[0] = 1'b1;
    wait_done(0);
    chk("ovr_done", done[0], 1);
    chk("ovr_one_write", wq0.size(), 1);
    chk("ovr_write", wq0.size() > 0 ? wq0[0] : 48'h0, {16'h0000, 32'h44332211});
    do_reset(1);
    send_seq(1, '{8'h01, 8'h00, 8'hAA, 8'hBB});
    repeat (49) @(negedge clk);
    chk("tmo_before", {tmo[1], busy[1]}, 2'b01);
    @(negedge clk);
    chk("tmo_hit", {tmo[1], busy[1]}, 2'b10);
    send_seq(1, '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
    wait_done(1);
    chk("tmo_write", wq1.size() == 1 ? wq1[0] : 48'h0, {16'hFFFC, 32'hDEADBEEF});
    chk("tmo_done_sticky", {done[1], tmo[1]}, 2'b11);
    do_reset(1);
    send(1, 8'h02);
    send(1, 8'h00);
    send_seq(1, p8);
    wait_done(1);
    chk("wrap_count", wq1.size(), 2);
    chk("wrap_first", wq1.size() > 0 ? wq1[0] : 48'h0, {16'hFFFC, 32'h44332211});
    chk("wrap_second", wq1.size() > 1 ? wq1[1] : 48'h0, {16'h0000, 32'h88776655});
    chk("wrap_flags", {done[1], ovr[1], tmo[1]}, 3'b100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
